// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/stall bundle between the 5-stage pipeline and its hazard sequencer.
// master: sequencer side (drives latch controls, flags, counters); slave: pipeline side.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic             rs1_used_ID;
    logic             rs2_used_ID;
    logic [4:0]       rd_EX;
    logic             mem_read_EX;
    logic             rd_we_EX;
    logic             branch_taken_EX;
    logic             dmem_req;
    logic             dmem_ack;
    logic             PC_EN;
    logic             IFID_EN;
    logic             IFID_Data_stall;
    logic             IFID_flush;
    logic             IDEX_bubble;
    logic             EXMEM_EN;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
        input  rd_EX, mem_read_EX, rd_we_EX,
        input  branch_taken_EX, dmem_req, dmem_ack,
        output PC_EN, IFID_EN, IFID_Data_stall, IFID_flush,
        output IDEX_bubble, EXMEM_EN, bus_err,
        output stall_cnt, flush_cnt
    );

    modport slave (
        output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
        output rd_EX, mem_read_EX, rd_we_EX,
        output branch_taken_EX, dmem_req, dmem_ack,
        input  PC_EN, IFID_EN, IFID_Data_stall, IFID_flush,
        input  IDEX_bubble, EXMEM_EN, bus_err,
        input  stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: freeze > branch flush > load-use stall, plus perf counters.
// Ports: clk, rst (async active-low), hz (master modport of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl #(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.master hz
);
    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);
    localparam logic [2:0] FL_INIT = 3'(BR_PENALTY - 1);

    typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       flush_left_q, flush_left_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze_req, lu_hazard, in_flush;
    logic do_freeze, do_branch, do_flush, do_stall;

    assign freeze_req = hz.dmem_req & ~hz.dmem_ack;

    assign lu_hazard = hz.mem_read_EX & hz.rd_we_EX & (hz.rd_EX != 5'd0) &
                       ((hz.rs1_used_ID & (hz.rs1_ID == hz.rd_EX)) |
                        (hz.rs2_used_ID & (hz.rs2_ID == hz.rd_EX)));

    // Leaving FREEZE resumes a held flush in the same cycle.
    assign in_flush = (state_q == FLUSH) ||
                      ((state_q == FREEZE) && (flush_left_q != 3'd0));

    assign do_freeze = freeze_req;
    assign do_branch = ~freeze_req & hz.branch_taken_EX;
    assign do_flush  = ~freeze_req & ~hz.branch_taken_EX & in_flush;
    assign do_stall  = ~freeze_req & ~hz.branch_taken_EX & ~in_flush & lu_hazard;

    always_comb begin
        hz.PC_EN           = 1'b1;
        hz.IFID_EN         = 1'b1;
        hz.IFID_Data_stall = 1'b0;
        hz.IFID_flush      = 1'b0;
        hz.IDEX_bubble     = 1'b0;
        hz.EXMEM_EN        = 1'b1;
        state_d      = RUN;
        flush_left_d = flush_left_q;
        tmo_cnt_d    = '0;
        bus_err_d    = bus_err_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        unique case (1'b1)
            do_freeze: begin
                hz.PC_EN    = 1'b0;
                hz.IFID_EN  = 1'b0;
                hz.EXMEM_EN = 1'b0;
                state_d     = FREEZE;
                tmo_cnt_d   = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
                if (tmo_cnt_d == TMO_MAX) bus_err_d = 1'b1;
            end
            do_branch: begin
                hz.IFID_flush  = 1'b1;
                hz.IDEX_bubble = 1'b1;
                flush_left_d   = FL_INIT;
                state_d        = (FL_INIT != 3'd0) ? FLUSH : RUN;
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            end
            do_flush: begin
                hz.IFID_flush = 1'b1;
                flush_left_d  = flush_left_q - 3'd1;
                state_d       = (flush_left_q > 3'd1) ? FLUSH : RUN;
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            end
            do_stall: begin
                hz.PC_EN           = 1'b0;
                hz.IFID_Data_stall = 1'b1;
                hz.IDEX_bubble     = 1'b1;
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            flush_left_q <= '0;
            tmo_cnt_q    <= '0;
            bus_err_q    <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            tmo_cnt_q    <= tmo_cnt_d;
            bus_err_q    <= bus_err_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hz.bus_err   = bus_err_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed and random steps against a cycle-level model.
// Model tracks remaining flush cycles, freeze length and counters as plain integers.
module tb_pipe_hazard_ctrl;
    localparam int P   = 2;
    localparam int MT  = 4;
    localparam int CW  = 16;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    int m_rem, m_tmo, m_scnt, m_fcnt;
    bit m_berr;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .BR_PENALTY (P),
        .MEM_TIMEOUT(MT),
        .CNT_W      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.PC_EN, bus.IFID_EN, bus.IFID_Data_stall,
                bus.IFID_flush, bus.IDEX_bubble, bus.EXMEM_EN};
    endfunction

    task automatic set_in(input bit br, input bit req, input bit ack,
                          input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit mr, input bit we);
        bus.branch_taken_EX = br;
        bus.dmem_req = req;
        bus.dmem_ack = ack;
        bus.rs1_ID = 5'(rs1);
        bus.rs2_ID = 5'(rs2);
        bus.rs1_used_ID = u1;
        bus.rs2_used_ID = u2;
        bus.rd_EX = 5'(rd);
        bus.mem_read_EX = mr;
        bus.rd_we_EX = we;
    endtask

    task automatic model_reset();
        m_rem = 0; m_tmo = 0; m_scnt = 0; m_fcnt = 0; m_berr = 0;
    endtask

    // One clock: check current outputs against the model, then advance both.
    task automatic step(input string tag);
        bit frz, lu;
        logic [5:0] e;
        #1;
        frz = bus.dmem_req && !bus.dmem_ack;
        lu = bus.mem_read_EX && bus.rd_we_EX && bus.rd_EX != 0 &&
             ((bus.rs1_used_ID && bus.rs1_ID == bus.rd_EX) ||
              (bus.rs2_used_ID && bus.rs2_ID == bus.rd_EX));
        if (frz)                       e = 6'b000000;
        else if (bus.branch_taken_EX)  e = 6'b110111;
        else if (m_rem > 0)            e = 6'b110101;
        else if (lu)                   e = 6'b011011;
        else                           e = 6'b110001;
        chk({tag, "_outs"}, 32'(outs()), 32'(e));
        chk({tag, "_berr"}, 32'(bus.bus_err), 32'(m_berr));
        chk({tag, "_scnt"}, 32'(bus.stall_cnt), 32'(m_scnt));
        chk({tag, "_fcnt"}, 32'(bus.flush_cnt), 32'(m_fcnt));
        if (frz) begin
            if (m_tmo < MT) m_tmo++;
            if (m_tmo >= MT) m_berr = 1;
        end else begin
            m_tmo = 0;
            if (bus.branch_taken_EX) begin
                m_rem = P - 1;
                if (m_fcnt < SAT) m_fcnt++;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_fcnt < SAT) m_fcnt++;
            end else if (lu) begin
                if (m_scnt < SAT) m_scnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        model_reset();
        #2;
        chk("rst_outs", 32'(outs()), 32'(6'b110001));
        chk("rst_scnt", 32'(bus.stall_cnt), 0);
        chk("rst_fcnt", 32'(bus.flush_cnt), 0);
        chk("rst_berr", 32'(bus.bus_err), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        set_in(0, 0, 0, 1, 5, 0, 1, 5, 1, 1);
        step("lu");
        chk("lu_cnt", 32'(bus.stall_cnt), 1);
        idle(); step("idle0");
        set_in(0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
        step("lu_rd0");
        set_in(0, 0, 0, 7, 3, 0, 1, 7, 1, 1);
        step("lu_rs1unused");
        chk("lu_nostall", 32'(bus.stall_cnt), 1);

        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("br_c0");
        idle(); step("br_c1");
        step("br_c2");
        chk("br_fcnt", 32'(bus.flush_cnt), 2);

        set_in(1, 0, 0, 5, 0, 1, 0, 5, 1, 1);
        step("br_lu");
        chk("br_lu_scnt", 32'(bus.stall_cnt), 1);
        idle(); step("br_lu_c1");

        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("frzfl_c0");
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("frzfl_hold");
        set_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("frzfl_ack");
        idle(); step("frzfl_run");
        chk("frzfl_fcnt", 32'(bus.flush_cnt), 6);

        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("tmo");
        chk("tmo_berr", 32'(bus.bus_err), 1);
        idle(); step("tmo_after");
        chk("tmo_sticky", 32'(bus.bus_err), 1);

        for (int i = 0; i < 2000; i++) begin
            set_in($urandom_range(0, 9) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
            step("rnd");
        end

        idle();
        step("pre_rst");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rstfl_br");
        idle();
        #($urandom_range(1, 3));
        rst = 1'b0;
        #1;
        chk("rstfl_outs", 32'(outs()), 32'(6'b110001));
        chk("rstfl_scnt", 32'(bus.stall_cnt), 0);
        chk("rstfl_fcnt", 32'(bus.flush_cnt), 0);
        chk("rstfl_berr", 32'(bus.bus_err), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("rstfl_run");

        set_in(0, 0, 0, 9, 0, 1, 0, 9, 1, 1);
        for (int i = 0; i < SAT; i++) step("sat");
        chk("sat_full", 32'(bus.stall_cnt), 32'(SAT));
        step("sat_more");
        chk("sat_hold", 32'(bus.stall_cnt), 32'(SAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the control inputs of the IF/ID latch (EN, Data_stall, flush), the PC enable, and the ID/EX bubble insert. It arbitrates three hazard sources in a fixed priority order: data-memory wait freeze, taken branch/jump flush, and load-use stall. It also keeps saturating stall/flush performance counters and a sticky bus-timeout flag.

Parameters:
BR_PENALTY, 1, cycles of IF/ID flush per taken branch/jump (1..7); ID/EX bubble is inserted on the first flush cycle only
MEM_TIMEOUT, 255, max consecutive freeze cycles before bus_err sets (1..65535)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rs1_ID  in  5  rs1 index of instruction in ID
rs2_ID  in  5  rs2 index of instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  5  destination index of instruction in EX
mem_read_EX  in  1  EX instruction is a load
rd_we_EX  in  1  EX instruction writes rd
branch_taken_EX  in  1  branch/jump resolved taken in EX (one-cycle pulse per instruction)
dmem_req  in  1  MEM stage has an outstanding data-memory access
dmem_ack  in  1  data memory completes the access this cycle
PC_EN  out  1  PC register update enable
IFID_EN  out  1  IF/ID latch EN
IFID_Data_stall  out  1  IF/ID Data_stall
IFID_flush  out  1  IF/ID flush (inserts NOP 0x00000013)
IDEX_bubble  out  1  zero ID/EX control bits this cycle
EXMEM_EN  out  1  EX/MEM and MEM/WB enable
bus_err  out  1  sticky data-memory timeout flag
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  flush cycles, saturating

Behaviour:
- FSM states: RUN, FREEZE, FLUSH. On reset: RUN. Reset values: PC_EN=1, IFID_EN=1, EXMEM_EN=1, all others 0, counters 0, flush_left=0, tmo_cnt=0.
- Outputs are combinational from the current state and the inputs. State, counters and flags are registered.
- freeze_req = dmem_req & ~dmem_ack.
- lu_hazard = mem_read_EX & rd_we_EX & (rd_EX != 0) & ((rs1_used_ID & rs1_ID == rd_EX) | (rs2_used_ID & rs2_ID == rd_EX)).
- Priority, highest first: freeze_req, then branch_taken_EX / FLUSH state, then lu_hazard.
- Freeze cycle (freeze_req=1, any state):
  - PC_EN=0, IFID_EN=0, EXMEM_EN=0, IDEX_bubble=0, flush=0, Data_stall=0.
  - Next state FREEZE; a pending FLUSH count is held, not decremented.
  - tmo_cnt increments. When it reaches MEM_TIMEOUT, bus_err sets to 1 and stays set until reset. tmo_cnt saturates.
  - Leaving freeze (freeze_req=0) clears tmo_cnt. The next state is FLUSH if flush_left>0, else RUN. Normal evaluation applies in that same cycle.
- A branch_taken_EX that arrives during freeze is ignored. The EX stage holds it, so the source re-asserts it after the freeze.
- Flush cycle (branch_taken_EX=1 with no freeze):
  - IFID_flush=1, IDEX_bubble=1, PC_EN=1 (PC takes the target), IFID_EN=1.
  - flush_left <= BR_PENALTY-1. Next state is FLUSH if that value is >0, else RUN.
- In FLUSH with no freeze: IFID_flush=1, IDEX_bubble=0, PC_EN=1. flush_left decrements, and the FSM goes to RUN when it reaches 0.
- A new branch_taken_EX in FLUSH reloads flush_left.
- flush_cnt increments on every flush cycle.
- Load-use cycle (lu_hazard, no freeze, no flush): PC_EN=0, IFID_EN=1, IFID_Data_stall=1, IDEX_bubble=1; stall_cnt increments. This lasts exactly one cycle because the load advances to MEM.
- Simultaneous branch and load-use: the flush wins and no stall is counted.
- Otherwise (RUN): PC_EN=1, IFID_EN=1, EXMEM_EN=1, and the remaining outputs are 0.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously, including a pending flush and bus_err.

Test Plan:
- Reset: rst=0 at random time during FLUSH → same cycle PC_EN=1, IFID_flush=0, counters=0, bus_err=0; release → RUN.
- Load-use: mem_read_EX=1, rd_we_EX=1, rd_EX=5, rs2_ID=5, rs2_used_ID=1 for 1 cycle → PC_EN=0, IFID_Data_stall=1, IDEX_bubble=1, stall_cnt=1.
- Load-use with rd_EX=0, or with rs1_ID matching rd_EX while rs1_used_ID=0 → no stall.
- Branch, BR_PENALTY=2: branch_taken_EX pulse → cycle0: flush=1, bubble=1; cycle1: flush=1, bubble=0; cycle2 back in RUN; flush_cnt=2.
- Priority: branch_taken_EX and lu_hazard in the same cycle → flush only, stall_cnt unchanged. dmem_req=1, dmem_ack=0 during FLUSH → all enables 0, flush_left held; after ack the remaining flush cycle completes.
- Timeout with MEM_TIMEOUT=4: dmem_req=1, ack=0 for 6 cycles → bus_err=1 from the 4th freeze cycle and stays 1 after ack. Drive stall_cnt to 0xFFFF, then one more stall → stays 0xFFFF.
